// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  localparam int N_DEF = 32;
  localparam int R_DEF = 6;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Byte program counter: asynchronously reset register with a load enable.
module pc_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // PC storage; holds its value unless a load is requested
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID holding register with decode backpressure,
// redirect/flush handling and a halt state at the end of instruction memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int r = R_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_data,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  input  logic         dec_ready,
  output logic         instr_valid,
  output logic [n-1:0] instr,
  output logic [n-1:0] instr_pc,
  output logic         halted,
  output logic         misalign_err
);

  // One past the last byte of instruction memory, one bit wider than the PC
  localparam logic [n:0] L_MEM_BYTES = {{(n-r-2){1'b0}}, 1'b1, {(r+2){1'b0}}};

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic         r_instr_valid;
  logic [n-1:0] r_instr;
  logic [n-1:0] r_instr_pc;
  logic         r_misalign;
  logic [n-1:0] w_pc;
  logic [n:0]   w_pc_sum;
  logic         w_at_end;
  logic         w_adv;
  logic         w_redir_oor;
  logic [n-1:0] w_redir_aligned;
  logic         w_pc_load;
  logic [n-1:0] w_pc_d;
  logic         w_halted;

  assign w_pc_sum        = {1'b0, w_pc} + (n+1)'(4);
  assign w_at_end        = (w_pc_sum >= L_MEM_BYTES);
  assign w_redir_aligned = {redirect_pc[n-1:2], 2'b00};
  assign w_redir_oor     = ({1'b0, redirect_pc} >= L_MEM_BYTES);
  assign w_adv           = (r_state == FETCH) && !stall && !redirect_valid &&
                           (!r_instr_valid || dec_ready);

  // Redirect wins; otherwise step by one word unless the last word was just fetched
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_d    = w_pc;
    if (redirect_valid) begin
      w_pc_load = 1'b1;
      w_pc_d    = w_redir_aligned;
    end else if (w_adv && !w_at_end) begin
      w_pc_load = 1'b1;
      w_pc_d    = w_pc_sum[n-1:0];
    end else begin
      w_pc_load = 1'b0;
      w_pc_d    = w_pc;
    end
  end

  pc_reg #(.W(n)) u_pc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_pc_load),
    .i_d     (w_pc_d),
    .o_q     (w_pc)
  );

  assign imem_addr = w_pc[r+1:2];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_redir_oor ? HALT : FETCH;
    end else if (w_adv && w_at_end) begin
      w_state_next = HALT;
    end else begin
      w_state_next = r_state;
    end
  end

  // FSM outputs
  always_comb begin
    w_halted = 1'b0;
    case (r_state)
      FETCH:   w_halted = 1'b0;
      HALT:    w_halted = 1'b1;
      default: w_halted = 1'b0;
    endcase
  end

  // IF/ID register: flush on redirect, load on advance, drain on decode accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else if (redirect_valid) begin
      r_instr_valid <= 1'b0;
    end else if (w_adv) begin
      r_instr_valid <= 1'b1;
      r_instr       <= imem_data;
      r_instr_pc    <= w_pc;
    end else if (r_instr_valid && dec_ready) begin
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= r_instr_valid;
    end
  end

  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end else begin
      r_misalign <= r_misalign;
    end
  end

  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign halted       = w_halted;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a 64-word instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        misalign_err;

  logic [31:0] mem [64];
  int errors;
  int checks;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        dr;
    logic        ev;
    logic [31:0] epc;
    logic [5:0]  ea;
    logic        eh;
    logic        em;
  } vec_t;

  vec_t vecs[26];

  fetch_unit #(.n(32), .r(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hC0DE_0000 | {26'h0, pc[7:2]};
  endfunction

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic dr, input logic ev, input logic [31:0] epc,
                              input logic [5:0] ea, input logic eh, input logic em);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.dr = dr;
    v.ev = ev; v.epc = epc; v.ea = ea; v.eh = eh; v.em = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [5:0] ea, input logic eh, input logic em);
    chk({tag, " valid"}, {31'h0, instr_valid}, {31'h0, ev});
    if (ev) begin
      chk({tag, " instr_pc"}, instr_pc, epc);
      chk({tag, " instr"}, instr, word_at(epc));
    end
    chk({tag, " imem_addr"}, {26'h0, imem_addr}, {26'h0, ea});
    chk({tag, " halted"}, {31'h0, halted}, {31'h0, eh});
    chk({tag, " misalign"}, {31'h0, misalign_err}, {31'h0, em});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    //            st    rv    rpc          dr    ev    epc          ea     eh    em
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h00,      6'd1,  1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h04,      6'd2,  1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h08,      6'd3,  1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h08,      6'd3,  1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h08,      6'd3,  1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h08,      6'd3,  1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0C,      6'd4,  1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h10,      6'd5,  1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 32'h20,      1'b1, 1'b0, 32'h00,      6'd8,  1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h20,      6'd9,  1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 32'h22,      1'b1, 1'b0, 32'h00,      6'd8,  1'b0, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h20,      6'd9,  1'b0, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h00,      6'd9,  1'b0, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h24,      6'd10, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 1'b1, 32'hF4,      1'b1, 1'b0, 32'h00,      6'd61, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'hF4,      6'd62, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'hF8,      6'd63, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'hFC,      6'd63, 1'b1, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h00,      6'd63, 1'b1, 1'b1);
    vecs[19] = mk(1'b0, 1'b1, 32'h10,      1'b1, 1'b0, 32'h00,      6'd4,  1'b0, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h10,      6'd5,  1'b0, 1'b1);
    vecs[21] = mk(1'b0, 1'b1, 32'h100,     1'b1, 1'b0, 32'h00,      6'd0,  1'b1, 1'b1);
    vecs[22] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h00,      6'd0,  1'b1, 1'b1);
    vecs[23] = mk(1'b0, 1'b1, 32'h0,       1'b1, 1'b0, 32'h00,      6'd0,  1'b0, 1'b1);
    vecs[24] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h00,      6'd1,  1'b0, 1'b1);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h04,      6'd2,  1'b0, 1'b1);

    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;
    #2;
    chk_state("reset", 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    chk("reset instr", instr, 32'h0);
    chk("reset instr_pc", instr_pc, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      stall          = vecs[i].st;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      dec_ready      = vecs[i].dr;
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ea,
                vecs[i].eh, vecs[i].em);
    end

    // Asynchronous reset between edges, then restart from address 0
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;
    reset_n        = 1'b0;
    #1;
    chk_state("midrst", 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    chk("midrst instr", instr, 32'h0);
    chk("midrst instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("restart0", 1'b1, 32'h00, 6'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("restart1", 1'b1, 32'h04, 6'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning register/instruction width in bits.
REQ-002 The block SHALL have parameter r, default 6, meaning word-address width of the instruction memory (2**r words).
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_addr  output  r  word address to instruction memory, equal to pc[r+1:2].
REQ-006 The block SHALL have port imem_data  input  n  instruction word returned combinationally for imem_addr.
REQ-007 The block SHALL have port stall  input  1  hazard stall; no new fetch while high.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 The block SHALL have port redirect_pc  input  n  byte target of the redirect.
REQ-010 The block SHALL have port dec_ready  input  1  decode accepts the held instruction.
REQ-011 The block SHALL have port instr_valid  output  1  instr/instr_pc hold a valid fetched word.
REQ-012 The block SHALL have port instr  output  n  fetched instruction (IF/ID register).
REQ-013 The block SHALL have port instr_pc  output  n  byte address of instr.
REQ-014 The block SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-015 The block SHALL have port misalign_err  output  1  sticky flag, redirect target not word-aligned.

Function
REQ-016 The block SHALL hold a byte PC register; imem_addr SHALL be combinational from the PC register only.
REQ-017 The FSM SHALL have states FETCH and HALT.
REQ-018 adv SHALL be defined as (state==FETCH) && !stall && !redirect_valid && (!instr_valid || dec_ready).
REQ-019 On adv the block SHALL register instr<=imem_data, instr_pc<=pc and instr_valid<=1, giving one-cycle latency from PC to instr.
REQ-020 On adv with pc+4 < 4*2**r the block SHALL set pc<=pc+4.
REQ-021 On adv with pc+4 >= 4*2**r the block SHALL deliver the last word, hold pc, and go to HALT.
REQ-022 While instr_valid=1 and dec_ready=0, instr, instr_pc and instr_valid SHALL stay stable.
REQ-023 When instr_valid=1, dec_ready=1 and not adv, the block SHALL clear instr_valid.
REQ-024 When instr_valid=1 and stall=1, the block SHALL still honour dec_ready per REQ-023.
REQ-025 Redirect SHALL take priority over stall, backpressure and HALT: instr_valid<=0 (flush), pc<={redirect_pc[n-1:2],2'b00}, state<=FETCH.
REQ-026 On redirect, if redirect_pc[1:0]!=0, misalign_err SHALL be set to 1 and stay set until reset.
REQ-027 On redirect, if redirect_pc >= 4*2**r, the block SHALL load pc, go to HALT and issue no fetch.
REQ-028 In HALT the block SHALL perform no fetch; a pending instr_valid SHALL still drain via dec_ready.
REQ-029 PC arithmetic SHALL be n-bit unsigned with no wrap past memory range (REQ-021 and REQ-027 apply instead).

Reset
REQ-030 While reset_n=0 the block SHALL force pc=0, state=FETCH, instr_valid=0, instr=0, instr_pc=0, halted=0 and misalign_err=0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard any held instruction; the first fetch after release SHALL be from address 0 on the first clk edge with reset_n=1.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the state enum {FETCH, HALT} and the default widths N_DEF=32 and R_DEF=6.
REQ-033 The block SHALL contain one sub-module, pc_reg: an async-reset n-bit register with load enable.
REQ-034 The top-level test SHALL instantiate fetch_unit directly driving the instruction memory (n=32, r=6).

Verification
REQ-035 The bench SHALL cover this scenario: reset release with dec_ready=1 and memory words 0..3 preloaded -> instr_pc 0,4,8,12 on consecutive cycles, instr_valid=1 from cycle 1.
REQ-036 The bench SHALL cover this scenario: dec_ready=0 for 3 cycles at instr_pc=8 -> instr and instr_pc held, imem_addr held at 3, no word skipped after release.
REQ-037 The bench SHALL cover this scenario: redirect_valid=1 and stall=1 simultaneously with redirect_pc=0x20 -> next cycle instr_valid=0 and imem_addr=8, then instr_pc=0x20.
REQ-038 The bench SHALL cover this scenario: redirect_pc=0x22 -> misalign_err=1 (sticky) and fetch from 0x20.
REQ-039 The bench SHALL cover this scenario: run to pc=0xFC -> instr_pc=0xFC delivered, halted=1, then redirect to 0x10 -> FETCH resumes at 0x10.
REQ-040 The bench SHALL cover this scenario: reset_n pulsed low mid-stream between edges -> outputs zero immediately, fetch restarts at 0.
